// File: rtl/bsg_pkg.sv
// Shared types and helpers for the bsg_stream_tx transmit core.
package bsg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int unsigned GRAY_MAX_W = 64;

  // Binary-to-Gray over a fixed maximum width; callers zero-extend and truncate.
  function automatic logic [GRAY_MAX_W-1:0] gray_enc(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/bsg_fifo.sv
// Synchronous FIFO with occupancy count; read data is the head entry, no bypass.
module bsg_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       SYS_CLK,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok_c;
  logic              pop_ok_c;

  assign full      = (level == LVL_W'(DEPTH));
  assign empty     = (level == '0);
  assign push_ok_c = push & ~full;
  assign pop_ok_c  = pop & ~empty;
  assign pop_data  = mem[rd_ptr];

  always_ff @(posedge SYS_CLK) begin
    if (push_ok_c) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge SYS_CLK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok_c, pop_ok_c})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/bsg_stream_tx.sv
// Buffered bit-stream transmitter: FIFO, optional Gray encode, MSB-first
// symbol serialiser at a programmable rate, and a sticky drain interrupt.
module bsg_stream_tx
  import bsg_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned BITS_PER_SYM = 2,
  parameter int unsigned GRAY_EN      = 1,
  parameter int unsigned DIV_W        = 8
) (
  input  logic                      SYS_CLK,
  input  logic                      reset,
  input  logic                      wr_valid,
  input  logic [DATA_W-1:0]         wr_data,
  output logic                      wr_ready,
  input  logic                      tx_enable,
  input  logic [DIV_W-1:0]          baud_div,
  input  logic                      int_mask,
  input  logic                      int_clr,
  output logic [BITS_PER_SYM-1:0]   sym_out,
  output logic                      sym_strobe,
  output logic                      busy,
  output logic                      int_flag,
  output logic                      irq,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int unsigned N     = DATA_W / BITS_PER_SYM;
  localparam int unsigned IDX_W = $clog2(N + 1);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  state_e            state;
  logic [DIV_W-1:0]  cnt;
  logic [IDX_W-1:0]  sym_idx;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] fifo_rdata;
  logic [DATA_W-1:0] enc_word_c;
  logic              full;
  logic              empty;
  logic              push_c;
  logic              pop_c;
  logic              tick_c;
  logic              last_sym_c;
  logic              int_set_c;

  bsg_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .SYS_CLK   (SYS_CLK),
    .reset     (reset),
    .push      (push_c),
    .push_data (wr_data),
    .pop       (pop_c),
    .pop_data  (fifo_rdata),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  assign wr_ready   = ~full;
  assign push_c     = wr_valid & ~full;
  assign tick_c     = (cnt == baud_div);
  assign last_sym_c = (sym_idx == IDX_W'(N));
  assign pop_c      = tick_c & tx_enable & ~empty & ((state == IDLE) | last_sym_c);
  assign enc_word_c = (GRAY_EN != 0) ? DATA_W'(gray_enc(GRAY_MAX_W'(fifo_rdata))) : fifo_rdata;
  assign int_set_c  = pop_c & (level == LVL_W'(1)) & ~push_c;
  assign irq        = int_flag & ~int_mask;

  // Symbol-rate divider; compares against the live baud_div so a shrink below the count wraps via max.
  always_ff @(posedge SYS_CLK) begin
    if (reset)                   cnt <= '0;
    else if (!(busy | tx_enable)) cnt <= '0;
    else if (tick_c)             cnt <= '0;
    else                         cnt <= cnt + DIV_W'(1);
  end

  always_ff @(posedge SYS_CLK) begin
    if (reset) begin
      state      <= IDLE;
      sym_idx    <= '0;
      shreg      <= '0;
      sym_out    <= '0;
      sym_strobe <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sym_strobe <= 1'b0;
      if (tick_c) begin
        if (pop_c) begin
          shreg      <= enc_word_c << BITS_PER_SYM;
          sym_out    <= enc_word_c[DATA_W-1 -: BITS_PER_SYM];
          sym_strobe <= 1'b1;
          sym_idx    <= IDX_W'(1);
          state      <= SHIFT;
          busy       <= 1'b1;
        end else if (state == SHIFT && !last_sym_c) begin
          shreg      <= shreg << BITS_PER_SYM;
          sym_out    <= shreg[DATA_W-1 -: BITS_PER_SYM];
          sym_strobe <= 1'b1;
          sym_idx    <= sym_idx + IDX_W'(1);
        end else if (state == SHIFT) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end
    end
  end

  // Set has priority over clear so a drain coinciding with int_clr is not lost.
  always_ff @(posedge SYS_CLK) begin
    if (reset) int_flag <= 1'b0;
    else       int_flag <= int_set_c | (int_flag & ~int_clr);
  end

endmodule

// File: tb/tb_bsg_stream_tx.sv
// Directed bench for bsg_stream_tx: Gray and binary instances share stimulus.
module tb_bsg_stream_tx;

  logic       SYS_CLK;
  logic       reset;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       tx_enable;
  logic [7:0] baud_div;
  logic       int_mask;
  logic       int_clr;

  logic       wr_ready,   b_wr_ready;
  logic [1:0] sym_out,    b_sym_out;
  logic       sym_strobe, b_sym_strobe;
  logic       busy,       b_busy;
  logic       int_flag,   b_int_flag;
  logic       irq,        b_irq;
  logic [2:0] level,      b_level;

  int checks = 0;
  int errors = 0;

  bsg_stream_tx #(.DATA_W(8), .DEPTH(4), .BITS_PER_SYM(2), .GRAY_EN(1), .DIV_W(8)) dut (
    .SYS_CLK(SYS_CLK), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .tx_enable(tx_enable), .baud_div(baud_div),
    .int_mask(int_mask), .int_clr(int_clr), .sym_out(sym_out),
    .sym_strobe(sym_strobe), .busy(busy), .int_flag(int_flag), .irq(irq),
    .level(level)
  );

  bsg_stream_tx #(.DATA_W(8), .DEPTH(4), .BITS_PER_SYM(2), .GRAY_EN(0), .DIV_W(8)) dut_b (
    .SYS_CLK(SYS_CLK), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(b_wr_ready), .tx_enable(tx_enable), .baud_div(baud_div),
    .int_mask(int_mask), .int_clr(int_clr), .sym_out(b_sym_out),
    .sym_strobe(b_sym_strobe), .busy(b_busy), .int_flag(b_int_flag), .irq(b_irq),
    .level(b_level)
  );

  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  task automatic step();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] words [5];
    logic [1:0] exp_gray [4];
    logic [1:0] exp_bin [4];
    logic [7:0] g;
    int         gap;
    int         n;
    int         strobes;

    words[0] = 8'h1E; words[1] = 8'h2D; words[2] = 8'h3C; words[3] = 8'h4B; words[4] = 8'h5A;
    exp_gray[0] = 2'b11; exp_gray[1] = 2'b10; exp_gray[2] = 2'b11; exp_gray[3] = 2'b10;
    exp_bin[0]  = 2'b10; exp_bin[1]  = 2'b11; exp_bin[2]  = 2'b01; exp_bin[3]  = 2'b00;

    reset = 1'b1; wr_valid = 1'b0; wr_data = '0; tx_enable = 1'b1;
    baud_div = '0; int_mask = 1'b0; int_clr = 1'b0;
    step(); step();
    chk("rst_level", 32'(level), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sym_out", 32'(sym_out), 0);
    chk("rst_strobe", 32'(sym_strobe), 0);
    chk("rst_int_flag", 32'(int_flag), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);

    // Gray 0xB4 -> 0xEE at full rate
    reset = 1'b0; wr_valid = 1'b1; wr_data = 8'hB4;
    step();
    wr_valid = 1'b0;
    chk("t1_level_after_push", 32'(level), 1);
    chk("t1_busy_before_load", 32'(busy), 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t1_strobe", 32'(sym_strobe), 1);
      chk("t1_sym", 32'(sym_out), 32'(exp_gray[k]));
      if (k == 0) begin
        chk("t1_level_after_pop", 32'(level), 0);
        chk("t1_int_flag", 32'(int_flag), 1);
        chk("t1_irq", 32'(irq), 1);
      end
    end
    step();
    chk("t1_busy_fall", 32'(busy), 0);
    chk("t1_strobe_end", 32'(sym_strobe), 0);
    chk("t1_sym_hold", 32'(sym_out), 2);

    // Binary instance, baud_div=3
    reset = 1'b1; baud_div = 8'd3;
    step();
    reset = 1'b0; wr_valid = 1'b1; wr_data = 8'hB4;
    step();
    wr_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      gap = 0;
      do begin
        step();
        gap++;
      end while (!b_sym_strobe && gap < 32);
      chk("t2_strobe_seen", 32'(b_sym_strobe), 1);
      chk("t2_sym", 32'(b_sym_out), 32'(exp_bin[k]));
      if (k > 0) chk("t2_strobe_gap", 32'(gap), 4);
    end
    n = 0;
    while (b_busy && n < 32) begin step(); n++; end
    chk("t2_busy_fall", 32'(b_busy), 0);
    chk("t2_int_flag", 32'(b_int_flag), 1);

    // Fill while disabled, then burst 16 symbols without gaps
    reset = 1'b1; baud_div = '0; tx_enable = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = words[i];
      if (i == 4) chk("t3_wr_ready_full", 32'(wr_ready), 0);
      step();
    end
    wr_valid = 1'b0;
    chk("t3_level_full", 32'(level), 4);
    tx_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      g = words[i] ^ (words[i] >> 1);
      for (int s = 0; s < 4; s++) begin
        step();
        chk("t3_strobe", 32'(sym_strobe), 1);
        chk("t3_sym", 32'(sym_out), 32'(2'(g >> (6 - 2 * s))));
      end
    end
    step();
    chk("t3_strobe_end", 32'(sym_strobe), 0);
    chk("t3_busy_end", 32'(busy), 0);
    chk("t3_level_end", 32'(level), 0);

    // Masked interrupt, then set-vs-clear priority
    reset = 1'b1; tx_enable = 1'b0; int_mask = 1'b1;
    step();
    reset = 1'b0;
    wr_valid = 1'b1; wr_data = 8'h00; step();
    wr_data = 8'hFF; step();
    wr_valid = 1'b0;
    tx_enable = 1'b1;
    n = 0;
    do begin step(); n++; end while ((busy || level != 0) && n < 40);
    chk("t4_drained", 32'(busy), 0);
    chk("t4_int_flag", 32'(int_flag), 1);
    chk("t4_irq_masked", 32'(irq), 0);
    int_mask = 1'b0;
    #1;
    chk("t4_irq_unmasked", 32'(irq), 1);
    int_clr = 1'b1;
    step();
    int_clr = 1'b0;
    chk("t4_int_cleared", 32'(int_flag), 0);
    tx_enable = 1'b0; wr_valid = 1'b1; wr_data = 8'h5A;
    step();
    wr_valid = 1'b0;
    chk("t4_level_one", 32'(level), 1);
    tx_enable = 1'b1; int_clr = 1'b1;
    step();
    chk("t4_set_wins", 32'(int_flag), 1);
    chk("t4_level_zero", 32'(level), 0);
    step();
    chk("t4_clr_after", 32'(int_flag), 0);
    int_clr = 1'b0;
    n = 0;
    while (busy && n < 32) begin step(); n++; end
    chk("t4_idle", 32'(busy), 0);

    // Drop tx_enable at the 2nd symbol with two words queued
    reset = 1'b1; tx_enable = 1'b0;
    step();
    reset = 1'b0;
    wr_valid = 1'b1; wr_data = 8'h81; step();
    wr_data = 8'h7E; step();
    wr_valid = 1'b0;
    chk("t5_level_two", 32'(level), 2);
    tx_enable = 1'b1;
    step();
    chk("t5_first_strobe", 32'(sym_strobe), 1);
    tx_enable = 1'b0;
    strobes = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sym_strobe) strobes++;
    end
    chk("t5_strobes", 32'(strobes), 4);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_level", 32'(level), 1);
    chk("t5_int_flag", 32'(int_flag), 0);

    // Reset mid-word
    tx_enable = 1'b1;
    step();
    chk("t6_load_strobe", 32'(sym_strobe), 1);
    chk("t6_int_flag_set", 32'(int_flag), 1);
    step();
    reset = 1'b1;
    step();
    chk("t6_level", 32'(level), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_sym_out", 32'(sym_out), 0);
    chk("t6_strobe", 32'(sym_strobe), 0);
    chk("t6_int_flag", 32'(int_flag), 0);
    reset = 1'b0;
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (sym_strobe) strobes++;
    end
    chk("t6_no_strobes", 32'(strobes), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_stream_tx.md
Name: bsg_stream_tx

Overview:
Parametrised bit-stream generator, successor to the two-register ping-pong BSG. It buffers DEPTH data words in a FIFO and optionally Gray-encodes each word. Each word is serialised into BITS_PER_SYM-wide symbols at a programmable symbol rate derived from SYS_CLK. It raises a maskable interrupt flag when the buffer drains and is the transmit core under the AMBA register front end.

Parameters:
DATA_W, 8, data word width
DEPTH, 4, FIFO entries; power of 2, >=2
BITS_PER_SYM, 2, symbol width; must divide DATA_W
GRAY_EN, 1, 1 = Gray-encode word at load (g = b ^ (b>>1)), 0 = pass binary
DIV_W, 8, width of symbol-rate divider

Ports:
SYS_CLK  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
wr_valid  in  1  push request
wr_data  in  DATA_W  word to push
wr_ready  out  1  FIFO not full (combinational from count)
tx_enable  in  1  TXENABLE: permit loading new words
baud_div  in  DIV_W  symbol period = baud_div+1 cycles
int_mask  in  1  INTMSK: 1 suppresses irq
int_clr  in  1  clears int_flag
sym_out  out  BITS_PER_SYM  current symbol, held for the symbol period
sym_strobe  out  1  one-cycle pulse with each new sym_out
busy  out  1  STATUS: shifter holds a word
int_flag  out  1  INTFLAG, sticky
irq  out  1  int_flag & ~int_mask
level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: FIFO empty, level=0, state IDLE, sym_out=0, sym_strobe=0, busy=0, int_flag=0, divider=0. Reset mid-word discards the word and the FIFO contents.
- Push: wr_valid & wr_ready writes wr_data. The word is visible for pop on the next cycle, with no bypass. A push while full is ignored. wr_ready depends only on current level, so a full FIFO refuses a push even when a pop occurs the same cycle.
- Divider: counts 0..baud_div while (busy | tx_enable). It is held at 0 otherwise. tick = (cnt==baud_div). baud_div=0 gives a tick every cycle. A baud_div change takes effect at the next wrap. If the count already exceeds the new value, the counter wraps through 0 at max.
- FSM states: IDLE, SHIFT.
  - IDLE, tick & tx_enable & level>0: pop the word, encode it, load the shifter, output the MSB symbol, and go to SHIFT with sym_idx=1.
  - IDLE, other conditions: stay in IDLE. sym_out holds its last value and sym_strobe=0.
  - SHIFT, tick & sym_idx<N (N=DATA_W/BITS_PER_SYM): output the next symbol MSB-first and increment sym_idx.
  - SHIFT, tick & sym_idx==N & tx_enable & level>0: pop and load the next word, output its first symbol with no gap, and stay in SHIFT.
  - SHIFT, tick & sym_idx==N with no word or tx_enable low: return to IDLE and clear busy.
- tx_enable low in SHIFT: the current word completes, and no new load occurs.
- sym_strobe=1 exactly in the cycle after each tick that updates sym_out; sym_out and sym_strobe are registered. busy=1 in SHIFT.
- int_flag is set in the cycle a pop makes level go 1->0. It is cleared by int_clr. If set and clear occur together, set wins.
- level updates in the cycle after a push or pop. A simultaneous push and pop leaves level unchanged.

Decomposition:
- Package bsg_pkg: state enum typedef (IDLE, SHIFT) and function gray_enc (parametrised by width via a let or a fixed max width plus masking).
- Sub-module bsg_fifo: synchronous FIFO (DATA_W, DEPTH) with push, pop, full, empty, level.
- Divider, FSM, shifter and interrupt logic live in bsg_stream_tx.

Test Plan:
- Defaults, baud_div=0, tx_enable=1, push 0xB4 -> Gray 0xEE. sym_out 11,10,11,10 on 4 consecutive strobes. busy falls after the 4th symbol. int_flag=1.
- GRAY_EN=0, baud_div=3, push 0xB4 -> symbols 10,11,01,00. Strobes are exactly 4 cycles apart.
- tx_enable=0, push 5 words -> first 4 accepted, 5th sees wr_ready=0, level=4. Enabling then emits 16 symbols with no strobe gap at baud_div=0.
- int_mask=1, drain 2 words -> int_flag=1 and irq=0. int_mask=0 gives irq=1. int_clr asserted in the same cycle as a new 1->0 drain keeps int_flag=1.
- tx_enable dropped at the 2nd symbol with 2 words queued -> the current word finishes, level stays 1, state is IDLE.
- reset asserted mid-word -> next cycle level=0, busy=0, sym_out=0, int_flag=0, and no further strobes.
